mode_sequencer: RTL and testbench

//  Automatic demo sequencer for the VGA pattern controller. Steps through the display

---
 rtl/mode_sequencer.sv | 134 +++++++++++++
 tb/tb_mode_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// Purpose: demo sequencer that steps VGA display modes on frame boundaries and ramps voffset.
// Latency: outputs registered; changes appear the cycle after the sampled frame_tick.
// Backpressure: skip_req is a held request answered by a 1-cycle skip_ack within one frame.
module mode_sequencer #(
   parameter int DWELL_FRAMES = 120,
   parameter int SCROLL_STEP  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic       skip_req,
   output logic       skip_ack,
   output logic [7:0] seq_params,
   output logic [7:0] voffset,
   output logic       mode_change
);

   localparam int CW = $clog2(DWELL_FRAMES + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_FRAMES - 1);
   localparam logic [7:0]    SCROLL_INC = 8'(SCROLL_STEP);

   typedef enum logic {IDLE, DWELL} state_t;

   state_t        state_q, state_d;
   logic [2:0]    step_q, step_d;
   logic [3:0]    pass_q, pass_d;
   logic [7:0]    voffset_q, voffset_d;
   logic [CW-1:0] dwell_cnt_q, dwell_cnt_d;
   logic          skip_pend_q, skip_pend_d;
   logic          skip_req_q, skip_req_d;
   logic          skip_ack_q, skip_ack_d;
   logic          mode_change_q, mode_change_d;
   logic [7:0]    seq_params_q, seq_params_d;

   logic          skip_rise;
   logic          advance;

   // Step table: mode 0 (PASS) and mode 3 are skipped.
   function automatic logic [2:0] mode_of(input logic [2:0] step);
      case (step)
         3'd0:    mode_of = 3'd1;
         3'd1:    mode_of = 3'd2;
         3'd2:    mode_of = 3'd4;
         3'd3:    mode_of = 3'd5;
         3'd4:    mode_of = 3'd6;
         default: mode_of = 3'd7;
      endcase
   endfunction

   // Next-state: FSM, dwell counting, scroll ramp, step advance and skip handshake.
   always_comb begin
      state_d       = state_q;
      step_d        = step_q;
      pass_d        = pass_q;
      voffset_d     = voffset_q;
      dwell_cnt_d   = dwell_cnt_q;
      skip_pend_d   = skip_pend_q;
      skip_req_d    = skip_req;
      skip_ack_d    = 1'b0;
      mode_change_d = 1'b0;
      advance       = 1'b0;
      // A request still held after its ack does not re-arm until it drops.
      skip_rise     = skip_req & ~skip_req_q;

      case (state_q)
         IDLE: begin
            if (enable) state_d = DWELL;
            if (frame_tick && skip_pend_q) advance = 1'b1;
         end
         default: begin
            if (!enable) begin
               // Leaving DWELL freezes the sequence for this cycle.
               state_d = IDLE;
            end else if (frame_tick) begin
               if (dwell_cnt_q == DWELL_LAST || skip_pend_q) begin
                  advance = 1'b1;
               end else begin
                  dwell_cnt_d = dwell_cnt_q + 1'b1;
                  voffset_d   = voffset_q + SCROLL_INC;
               end
            end
         end
      endcase

      if (advance) begin
         step_d        = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
         if (step_q == 3'd5) pass_d = pass_q + 4'd1;
         voffset_d     = 8'd0;
         dwell_cnt_d   = '0;
         mode_change_d = 1'b1;
         skip_ack_d    = skip_pend_q;
         skip_pend_d   = 1'b0;
      end

      // A request rising on a tick cycle waits for the following tick.
      if (skip_rise) skip_pend_d = 1'b1;

      seq_params_d = {1'b0, mode_of(step_d), pass_d};
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         step_q        <= 3'd0;
         pass_q        <= 4'd0;
         voffset_q     <= 8'd0;
         dwell_cnt_q   <= '0;
         skip_pend_q   <= 1'b0;
         skip_req_q    <= 1'b0;
         skip_ack_q    <= 1'b0;
         mode_change_q <= 1'b0;
         seq_params_q  <= 8'h10;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         pass_q        <= pass_d;
         voffset_q     <= voffset_d;
         dwell_cnt_q   <= dwell_cnt_d;
         skip_pend_q   <= skip_pend_d;
         skip_req_q    <= skip_req_d;
         skip_ack_q    <= skip_ack_d;
         mode_change_q <= mode_change_d;
         seq_params_q  <= seq_params_d;
      end
   end

   assign skip_ack    = skip_ack_q;
   assign seq_params  = seq_params_q;
   assign voffset     = voffset_q;
   assign mode_change = mode_change_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Purpose: directed self-checking bench for mode_sequencer (DWELL_FRAMES=4, SCROLL_STEP=3).
// Latency: outputs sampled 1ns after the rising edge that consumed frame_tick.
// Backpressure: skip_req held by the bench until skip_ack is seen, then dropped.
module tb_mode_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       enable;
   logic       skip_req;
   logic       skip_ack;
   logic [7:0] seq_params;
   logic [7:0] voffset;
   logic       mode_change;

   int n_assert = 0;
   int n_fail   = 0;
   int ack_cnt  = 0;
   int mc_cnt   = 0;
   int base;

   logic [2:0] modes [0:5] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

   mode_sequencer #(.DWELL_FRAMES(4), .SCROLL_STEP(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .enable      (enable),
      .skip_req    (skip_req),
      .skip_ack    (skip_ack),
      .seq_params  (seq_params),
      .voffset     (voffset),
      .mode_change (mode_change)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge, mid-cycle.
   always @(negedge clk) begin
      if (skip_ack)    ack_cnt++;
      if (mode_change) mc_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // One frame_tick pulse; returns 1ns after the edge that sampled it.
   task automatic tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; enable = 1'b0; skip_req = 1'b0;
      cyc(2);
      chk("rst_seq", seq_params, 8'h10);
      chk("rst_voff", voffset, 0);
      chk("rst_mc", mode_change, 0);
      chk("rst_ack", skip_ack, 0);

      // Auto dwell and first advance.
      @(negedge clk); reset = 1'b0; enable = 1'b1;
      tick(); chk("ramp1", voffset, 3);
      tick(); chk("ramp2", voffset, 6);
      tick(); chk("ramp3", voffset, 9);
      chk("ramp3_seq", seq_params, 8'h10);
      tick();
      chk("adv_seq", seq_params, 8'h20);
      chk("adv_voff", voffset, 0);
      chk("adv_mc", mode_change, 1);
      chk("adv_ack", skip_ack, 0);
      cyc(2);
      chk("mc_single", mc_cnt, 1);

      // Walk the rest of the table and the first wrap.
      for (int s = 2; s < 6; s++) begin
         ticks(4);
         chk("walk_seq", seq_params, {1'b0, modes[s], 4'h0});
      end
      ticks(4);
      chk("wrap1_seq", seq_params, 8'h11);
      for (int w = 2; w <= 16; w++) begin
         ticks(24);
         chk("wrap_pass", seq_params, {4'h1, 4'(w)});
      end

      // Manual skip at dwell_cnt=1; held request does not re-trigger.
      tick(); chk("sk_pre_voff", voffset, 3);
      @(negedge clk); skip_req = 1'b1;
      cyc(1);
      tick();
      chk("sk_seq", seq_params, 8'h20);
      chk("sk_ack", skip_ack, 1);
      chk("sk_mc", mode_change, 1);
      chk("sk_voff", voffset, 0);
      cyc(1);
      chk("sk_ack_drop", skip_ack, 0);
      base = ack_cnt;
      ticks(10);
      chk("sk_hold_noack", ack_cnt, base);
      chk("sk_hold_seq", seq_params, 8'h50);
      chk("sk_hold_voff", voffset, 6);
      @(negedge clk); skip_req = 1'b0;

      // Skip pending on the expiry tick gives a single advance.
      tick(); chk("exp_pre_voff", voffset, 9);
      @(negedge clk); skip_req = 1'b1;
      base = ack_cnt;
      cyc(1);
      tick();
      chk("exp_seq", seq_params, 8'h60);
      chk("exp_ack", skip_ack, 1);
      chk("exp_voff", voffset, 0);
      @(negedge clk); skip_req = 1'b0;
      tick();
      chk("exp_next_voff", voffset, 3);
      chk("exp_next_seq", seq_params, 8'h60);
      chk("exp_one_ack", ack_cnt, base + 1);

      // Manual mode freezes the ramp; a skip still advances.
      tick(); chk("man_pre_voff", voffset, 6);
      @(negedge clk); enable = 1'b0;
      base = mc_cnt;
      cyc(1);
      ticks(3);
      chk("man_voff", voffset, 6);
      chk("man_seq", seq_params, 8'h60);
      chk("man_no_mc", mc_cnt, base);
      @(negedge clk); skip_req = 1'b1;
      cyc(1);
      tick();
      chk("man_sk_seq", seq_params, 8'h70);
      chk("man_sk_ack", skip_ack, 1);
      chk("man_sk_voff", voffset, 0);
      @(negedge clk); skip_req = 1'b0; enable = 1'b1;
      cyc(1);
      ticks(3);
      chk("resume_voff", voffset, 9);
      tick();
      chk("resume_seq", seq_params, 8'h11);
      chk("resume_adv_voff", voffset, 0);

      // Reset with a skip pending at step 3.
      ticks(12);
      chk("pre_rst_seq", seq_params, 8'h51);
      @(negedge clk); skip_req = 1'b1;
      cyc(1);
      base = ack_cnt;
      @(negedge clk); reset = 1'b1; skip_req = 1'b0;
      cyc(1);
      chk("mid_rst_seq", seq_params, 8'h10);
      chk("mid_rst_voff", voffset, 0);
      chk("mid_rst_ack", skip_ack, 0);
      @(negedge clk); reset = 1'b0;
      cyc(1);
      ticks(3);
      chk("post_rst_voff", voffset, 9);
      chk("post_rst_seq", seq_params, 8'h10);
      chk("post_rst_noack", ack_cnt, base);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
